// File: rtl/iq_regread_pipe_n_pkg.sv
// rtl/iq_regread_pipe_n_pkg.sv - shared types for the issue-to-regread pipeline
package iq_regread_pipe_n_pkg;

    typedef struct packed {
        logic [31:0] immediate;
        logic [31:0] pc;
        logic [15:0] ctrl;
        logic [7:0]  robTag;
        logic [7:0]  lsqTag;
        logic [7:0]  physDest;
        logic [7:0]  physSrc1;
        logic [7:0]  physSrc2;
        logic [7:0]  fuType;
    } payloadPkt;

    localparam int PAYLOAD_W = $bits(payloadPkt);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CFG   = 2'd2
    } cfgState_e;

endpackage

// File: rtl/iq_regread_lane_pipe.sv
// rtl/iq_regread_lane_pipe.sv - one issue lane: DEPTH stages of valid and payload
module iq_regread_lane_pipe
    import iq_regread_pipe_n_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 laneActive,
    input  logic                 issueValid,
    input  logic [PAYLOAD_W-1:0] payloadIn,
    output logic [DEPTH-1:0]     stageValid,
    output logic [PAYLOAD_W-1:0] payloadOut
);

    logic [DEPTH-1:0]     validQ;
    logic [PAYLOAD_W-1:0] payloadQ [DEPTH];
    logic                 stage0Load;

    assign stage0Load = issueValid & laneActive & ~flush;

    // Payload only moves into stage 0 with a live entry; later stages just follow.
    always_ff @(posedge clk) begin
        if (reset) begin
            validQ <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                payloadQ[k] <= '0;
            end
        end else begin
            validQ[0] <= stage0Load;
            if (stage0Load) begin
                payloadQ[0] <= payloadIn;
            end
            for (int k = 1; k < DEPTH; k++) begin
                validQ[k]   <= validQ[k-1] & laneActive & ~flush;
                payloadQ[k] <= payloadQ[k-1];
            end
        end
    end

    assign stageValid = validQ;
    assign payloadOut = payloadQ[DEPTH-1];

endmodule

// File: rtl/iq_regread_pipe_n.sv
// rtl/iq_regread_pipe_n.sv - N-lane issue-to-regread pipeline with drain/config handshake
module iq_regread_pipe_n
    import iq_regread_pipe_n_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int DEPTH     = 2,
    localparam int OCC_W    = $clog2(NUM_LANES*DEPTH+1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_LANES-1:0]           laneActive_i,
    input  logic                           flush_i,
    input  logic                           cfgReq_i,
    input  logic                           cfgDone_i,
    input  logic [NUM_LANES-1:0]           valid_i,
    input  logic [NUM_LANES*PAYLOAD_W-1:0] payload_i,
    output logic [NUM_LANES-1:0]           valid_o,
    output logic [NUM_LANES*PAYLOAD_W-1:0] payload_o,
    output logic                           valid_bundle_o,
    output logic                           issueBlock_o,
    output logic                           cfgAck_o,
    output logic [OCC_W-1:0]               occupancy_o
);

    cfgState_e                      state;
    logic                           runIssue;
    logic [NUM_LANES*DEPTH-1:0]     stageValid;

    assign runIssue = (state == RUN);

    for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
        iq_regread_lane_pipe #(
            .DEPTH(DEPTH)
        ) uLane (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush_i),
            .laneActive (laneActive_i[i]),
            .issueValid (valid_i[i] & runIssue),
            .payloadIn  (payload_i[i*PAYLOAD_W +: PAYLOAD_W]),
            .stageValid (stageValid[i*DEPTH +: DEPTH]),
            .payloadOut (payload_o[i*PAYLOAD_W +: PAYLOAD_W])
        );
        assign valid_o[i] = stageValid[i*DEPTH + DEPTH - 1];
    end

    assign valid_bundle_o = |valid_o;

    always_comb begin
        occupancy_o = '0;
        for (int j = 0; j < NUM_LANES*DEPTH; j++) begin
            occupancy_o = occupancy_o + OCC_W'(stageValid[j]);
        end
    end

    // A flush seen in DRAIN empties every stage at the same edge, so CFG can follow immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            issueBlock_o <= 1'b0;
            cfgAck_o     <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (cfgReq_i) begin
                        state        <= DRAIN;
                        issueBlock_o <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (occupancy_o == '0 || flush_i) begin
                        state    <= CFG;
                        cfgAck_o <= 1'b1;
                    end
                end
                CFG: begin
                    if (cfgDone_i) begin
                        state        <= RUN;
                        issueBlock_o <= 1'b0;
                        cfgAck_o     <= 1'b0;
                    end
                end
                default: begin
                    state        <= RUN;
                    issueBlock_o <= 1'b0;
                    cfgAck_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iq_regread_pipe_n.sv
// tb/tb_iq_regread_pipe_n.sv - bench for iq_regread_pipe_n with issue-history reference model
module tb_iq_regread_pipe_n;

    localparam int NL   = 4;
    localparam int DEP  = 2;
    localparam int PW   = 128;
    localparam int OW   = $clog2(NL*DEP+1);
    localparam int MAXC = 4000;
    localparam int S_RUN = 0, S_DRAIN = 1, S_CFG = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NL-1:0]   laneActive_i, valid_i, valid_o;
    logic            flush_i, cfgReq_i, cfgDone_i;
    logic [NL*PW-1:0] payload_i, payload_o;
    logic            valid_bundle_o, issueBlock_o, cfgAck_o;
    logic [OW-1:0]   occupancy_o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Per-cycle history of what was driven and what the issue port accepted.
    logic [NL-1:0] hAcc [MAXC];
    logic [NL-1:0] hAct [MAXC];
    bit            hFlush [MAXC];
    bit            hRst [MAXC];
    logic [PW-1:0] hPay [MAXC][NL];
    int            mState [MAXC];

    iq_regread_pipe_n #(.NUM_LANES(NL), .DEPTH(DEP)) dut (
        .clk(clk), .reset(reset), .laneActive_i(laneActive_i), .flush_i(flush_i),
        .cfgReq_i(cfgReq_i), .cfgDone_i(cfgDone_i), .valid_i(valid_i), .payload_i(payload_i),
        .valid_o(valid_o), .payload_o(payload_o), .valid_bundle_o(valid_bundle_o),
        .issueBlock_o(issueBlock_o), .cfgAck_o(cfgAck_o), .occupancy_o(occupancy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // An entry issued in cycle c on lane i is still in flight at cycle n if nothing killed it since.
    function automatic bit alive(input int c, input int i, input int n);
        if (c < 0) return 1'b0;
        if (!hAcc[c][i]) return 1'b0;
        for (int m = c + 1; m < n; m++) begin
            if (hFlush[m] || hRst[m] || !hAct[m][i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int modelOcc(input int n);
        int cnt = 0;
        for (int c = n - DEP; c < n; c++)
            for (int i = 0; i < NL; i++)
                if (alive(c, i, n)) cnt++;
        return cnt;
    endfunction

    task automatic compare();
        logic [NL-1:0] ev;
        for (int i = 0; i < NL; i++) ev[i] = alive(cyc - DEP, i, cyc);
        chk("valid_o", PW'(valid_o), PW'(ev));
        chk("valid_bundle_o", PW'(valid_bundle_o), PW'(|ev));
        chk("occupancy_o", PW'(occupancy_o), PW'(modelOcc(cyc)));
        chk("issueBlock_o", PW'(issueBlock_o), PW'(mState[cyc] != S_RUN));
        chk("cfgAck_o", PW'(cfgAck_o), PW'(mState[cyc] == S_CFG));
        for (int i = 0; i < NL; i++)
            if (ev[i]) chk("payload_o", payload_o[i*PW +: PW], hPay[cyc-DEP][i]);
    endtask

    task automatic tick();
        int occ;
        hRst[cyc]   = reset;
        hFlush[cyc] = flush_i;
        hAct[cyc]   = laneActive_i;
        for (int i = 0; i < NL; i++) hPay[cyc][i] = payload_i[i*PW +: PW];
        hAcc[cyc] = (reset || flush_i || mState[cyc] != S_RUN) ? '0 : (valid_i & laneActive_i);
        occ = modelOcc(cyc);
        if (reset) mState[cyc+1] = S_RUN;
        else if (mState[cyc] == S_RUN) mState[cyc+1] = cfgReq_i ? S_DRAIN : S_RUN;
        else if (mState[cyc] == S_DRAIN) mState[cyc+1] = (occ == 0 || flush_i) ? S_CFG : S_DRAIN;
        else mState[cyc+1] = cfgDone_i ? S_RUN : S_CFG;
        @(posedge clk);
        #1;
        cyc++;
        compare();
    endtask

    task automatic idle();
        reset = 0; valid_i = '0; flush_i = 0; cfgReq_i = 0; cfgDone_i = 0;
    endtask

    task automatic setPay(input int lane, input logic [PW-1:0] v);
        payload_i[lane*PW +: PW] = v;
    endtask

    task automatic randPays();
        for (int i = 0; i < NL; i++) setPay(i, {$urandom, $urandom, $urandom, $urandom});
    endtask

    initial begin
        int w;
        mState[0] = S_RUN;
        reset = 1; laneActive_i = '0; valid_i = '0; flush_i = 0;
        cfgReq_i = 0; cfgDone_i = 0; payload_i = '0;
        tick(); tick();
        chk("rst_valid_o", PW'(valid_o), '0);
        chk("rst_occ", PW'(occupancy_o), '0);
        chk("rst_payload_zero", PW'(|payload_o), '0);

        // Single issue on lane 2
        idle(); laneActive_i = '1; tick();
        valid_i = 4'b0100; payload_i = '0; setPay(2, 'hA5); tick();
        chk("lane2_occ_t1", PW'(occupancy_o), 1);
        idle(); tick();
        chk("lane2_valid_t2", PW'(valid_o), 4'b0100);
        chk("lane2_payload_t2", payload_o[2*PW +: PW], 'hA5);
        chk("lane2_occ_t2", PW'(occupancy_o), 1);
        tick();
        chk("lane2_occ_t3", PW'(occupancy_o), 0);

        // Flush kills the third bundle
        valid_i = '1; randPays(); tick(); randPays(); tick();
        flush_i = 1; randPays(); tick();
        chk("flush_valid", PW'(valid_o), 0);
        chk("flush_occ", PW'(occupancy_o), 0);
        idle(); tick();
        chk("flush_valid_2", PW'(valid_o), 0);

        // Lane 1 deactivated with two entries in flight
        valid_i = '1; randPays(); tick(); randPays(); tick();
        chk("full_occ", PW'(occupancy_o), 8);
        valid_i = '0; laneActive_i = 4'b1101; tick();
        chk("drop_valid", PW'(valid_o), 4'b1101);
        chk("drop_occ", PW'(occupancy_o), 3);
        laneActive_i = '1; tick();

        // Configuration request with a full pipe
        valid_i = '1; randPays(); tick();
        cfgReq_i = 1; randPays(); tick();
        chk("cfg_block", PW'(issueBlock_o), 1);
        chk("cfg_occ8", PW'(occupancy_o), 8);
        cfgReq_i = 0; w = 0;
        while (!cfgAck_o && w < 3) begin randPays(); tick(); w++; end
        chk("cfg_ack_within3", PW'(cfgAck_o), 1);
        valid_i = '0; cfgDone_i = 1; tick();
        chk("cfg_done_unblock", PW'(issueBlock_o), 0);
        cfgDone_i = 0; valid_i = 4'b0001; setPay(0, 'h1234); tick();
        valid_i = '0; tick();
        chk("post_cfg_valid", PW'(valid_o), 4'b0001);
        chk("post_cfg_payload", payload_o[0 +: PW], 'h1234);

        // Flush during DRAIN
        valid_i = '1; randPays(); tick();
        cfgReq_i = 1; randPays(); tick();
        cfgReq_i = 0; valid_i = '0; flush_i = 1; tick();
        chk("drain_flush_ack", PW'(cfgAck_o), 1);
        chk("drain_flush_occ", PW'(occupancy_o), 0);
        flush_i = 0; cfgDone_i = 1; tick();
        chk("drain_done_run", PW'(issueBlock_o), 0);
        tick();
        chk("done_in_run_block", PW'(issueBlock_o), 0);
        chk("done_in_run_ack", PW'(cfgAck_o), 0);
        cfgDone_i = 0;

        // Reset while in CFG
        cfgReq_i = 1; tick(); cfgReq_i = 0; w = 0;
        while (!cfgAck_o && w < 6) begin tick(); w++; end
        chk("reach_cfg", PW'(cfgAck_o), 1);
        valid_i = '1; randPays(); tick();
        reset = 1; tick();
        chk("rstcfg_valid", PW'(valid_o), 0);
        chk("rstcfg_block", PW'(issueBlock_o), 0);
        chk("rstcfg_ack", PW'(cfgAck_o), 0);
        chk("rstcfg_occ", PW'(occupancy_o), 0);
        chk("rstcfg_payload", PW'(|payload_o), 0);
        idle(); valid_i = 4'b1000; setPay(3, 'hBEEF); tick();
        valid_i = '0; tick();
        chk("rstcfg_next_valid", PW'(valid_o), 4'b1000);
        chk("rstcfg_next_payload", payload_o[3*PW +: PW], 'hBEEF);

        // Randomized traffic
        for (int r = 0; r < 1500; r++) begin
            reset        = ($urandom_range(0, 99) == 0);
            flush_i      = ($urandom_range(0, 15) == 0);
            cfgReq_i     = ($urandom_range(0, 9) == 0);
            cfgDone_i    = ($urandom_range(0, 3) == 0);
            laneActive_i = ($urandom_range(0, 7) == 0) ? NL'($urandom) : '1;
            valid_i      = NL'($urandom);
            randPays();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
